// File: rtl/rpn_stack_engine.sv
// -----------------------------------------------------------------------------
// rpn_stack_engine
//
// Operand stack, opcode decode and ALU of an RPN calculator, driven through a
// valid/ready command port. Each command is accepted in IDLE, executes on the
// following edge in EXEC, and reports completion with a one-cycle done pulse
// together with an error code (OK / UNDERFLOW / OVERFLOW).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  engine can accept a command (high in IDLE)
//   cmd_op     in   4-bit opcode
//   cmd_data   in   operand for PUSH
//   top        out  stack[count-1], 0 when empty
//   next       out  stack[count-2], 0 when fewer than two entries
//   count      out  number of valid entries
//   done       out  one-cycle pulse when a command completes
//   err_code   out  result of the last completed command
// -----------------------------------------------------------------------------
module rpn_stack_engine #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             done,
  output logic [1:0]       err_code
);

  // Storage index width; DEPTH >= 2 keeps this at least 1 bit.
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_PUSH  = 4'd0,
    OP_POP   = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SLT   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_NOR   = 4'd10,
    OP_XOR   = 4'd11,
    OP_SWAP  = 4'd12,
    OP_DUP   = 4'd13,
    OP_CLEAR = 4'd14,
    OP_NOP   = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2
  } err_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] a_q;      // top at accept time
  logic [WIDTH-1:0] b_q;      // next at accept time
  logic [CW-1:0]    count_q;
  logic             done_q;
  err_e             err_q;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic             accept;
  logic             exec;

  // ---------------------------------------------------------------------------
  // Read side: outputs are gated by count so stale storage never leaks out.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] top_idx;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] push_idx;
  logic          has_one;
  logic          has_two;
  logic          full;

  assign top_idx  = AW'(count_q - CW'(1));
  assign next_idx = AW'(count_q - CW'(2));
  assign push_idx = AW'(count_q);
  assign has_one  = (count_q != '0);
  assign has_two  = (count_q >= CW'(2));
  assign full     = (count_q == CW'(DEPTH));

  assign top      = has_one ? stack_mem[top_idx]  : '0;
  assign next     = has_two ? stack_mem[next_idx] : '0;
  assign count    = count_q;
  assign done     = done_q;
  assign err_code = err_q;

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; that is what keeps combinational blocks free of latches.
  always_comb begin
    state_nxt = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign exec = (state_q == S_EXEC);

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res;
  logic             shamt_big;

  // Shift amount is the whole of A; anything >= WIDTH shifts everything out.
  assign shamt_big = (a_q >= WIDTH'(WIDTH));

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD: alu_res = b_q + a_q;
      OP_SUB: alu_res = b_q - a_q;
      OP_MUL: alu_res = b_q * a_q;
      OP_SHL: alu_res = shamt_big ? '0 : (b_q << a_q);
      OP_SHR: alu_res = shamt_big ? '0 : (b_q >> a_q);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (b_q < a_q)};
      OP_AND: alu_res = b_q & a_q;
      OP_OR:  alu_res = b_q | a_q;
      OP_NOR: alu_res = ~(b_q | a_q);
      OP_XOR: alu_res = b_q ^ a_q;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stack update decode: two write ports (only SWAP needs the second one) plus
  // the new count and error code. Error cases leave storage and count alone.
  // ---------------------------------------------------------------------------
  logic             wr0_en;
  logic [AW-1:0]    wr0_idx;
  logic [WIDTH-1:0] wr0_data;
  logic             wr1_en;
  logic [AW-1:0]    wr1_idx;
  logic [WIDTH-1:0] wr1_data;
  logic [CW-1:0]    count_nxt;
  err_e             err_nxt;

  always_comb begin
    wr0_en    = 1'b0;
    wr0_idx   = '0;
    wr0_data  = '0;
    wr1_en    = 1'b0;
    wr1_idx   = '0;
    wr1_data  = '0;
    count_nxt = count_q;
    err_nxt   = ERR_OK;
    case (op_q)
      OP_PUSH: begin
        if (full) begin
          err_nxt = ERR_OVER;
        end else begin
          wr0_en    = 1'b1;
          wr0_idx   = push_idx;
          wr0_data  = data_q;
          count_nxt = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (!has_one) err_nxt   = ERR_UNDER;
        else          count_nxt = count_q - CW'(1);
      end
      OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_SHR, OP_SLT,
      OP_AND, OP_OR, OP_NOR, OP_XOR: begin
        // Pop two, push one: the result lands where B was.
        if (!has_two) begin
          err_nxt = ERR_UNDER;
        end else begin
          wr0_en    = 1'b1;
          wr0_idx   = next_idx;
          wr0_data  = alu_res;
          count_nxt = count_q - CW'(1);
        end
      end
      OP_SWAP: begin
        if (!has_two) begin
          err_nxt = ERR_UNDER;
        end else begin
          wr0_en   = 1'b1;
          wr0_idx  = top_idx;
          wr0_data = b_q;
          wr1_en   = 1'b1;
          wr1_idx  = next_idx;
          wr1_data = a_q;
        end
      end
      OP_DUP: begin
        if (!has_one) begin
          err_nxt = ERR_UNDER;
        end else if (full) begin
          err_nxt = ERR_OVER;
        end else begin
          wr0_en    = 1'b1;
          wr0_idx   = push_idx;
          wr0_data  = a_q;
          count_nxt = count_q + CW'(1);
        end
      end
      OP_CLEAR: count_nxt = '0;
      default:  ;  // OP_NOP
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_nxt;
      done_q  <= exec;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
        a_q    <= top;
        b_q    <= next;
      end
      if (exec) begin
        count_q <= count_nxt;
        err_q   <= err_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset; count gates every read, so its
  // contents after reset are irrelevant and it can map onto plain flops/RAM.
  // A reset asserted during EXEC forces state_q to IDLE, so no write happens.
  always_ff @(posedge clk) begin
    if (exec && wr0_en) stack_mem[wr0_idx] <= wr0_data;
    if (exec && wr1_en) stack_mem[wr1_idx] <= wr1_data;
  end

endmodule
